square_display: RTL and testbench

Demonstration block that steps an operand n through 0..9 and computes n² with a sequential shift-add multiplier. It converts the result to BCD by double-dabble and drives two 2-digit seven-segment displays: SS1 shows n and SS2 shows n². Two status LEDs show whether a computation is in progress or a result is on display. It sits at the top of a board-level demo, directly between the board clock/reset and the display/LED pins.

---
 rtl/square_display.sv | 143 ++++++++++++++
 tb/tb_square_display.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/square_display.sv
// Steps n through 0..9, squares it with a 4-step shift-add multiplier, converts
// the product to BCD by double-dabble and shows n and n^2 on two 2-digit displays.
module square_display #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rstn,
  output logic       LED_RED,
  output logic       LED_GREEN,
  output logic [6:0] SS1_1,
  output logic [6:0] SS1_0,
  output logic [6:0] SS2_1,
  output logic [6:0] SS2_0
);

  typedef enum logic [1:0] {IDLE, MUL, CONV, SHOW} state_t;

  localparam logic [23:0] DWELL_LAST = 24'(TICK_DIV - 1);

  state_t      state, state_next;
  logic [3:0]  n;
  logic [6:0]  acc, acc_next;
  logic [7:0]  bcd, bcd_adj, bcd_next;
  logic [6:0]  shift_copy;
  logic [2:0]  iter;
  logic [23:0] dwell;
  logic [3:0]  n_tens, n_ones, sq_tens, sq_ones;
  logic        last_mul, last_conv, last_dwell;

  assign last_mul   = (iter == 3'd3);
  assign last_conv  = (iter == 3'd6);
  assign last_dwell = (dwell == DWELL_LAST);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Shift-add partial product and one double-dabble step (adjust, then shift).
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    acc_next = acc;
    if (n[iter[1:0]])
      acc_next = acc + (7'(n) << iter[1:0]);
    bcd_adj[3:0] = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
    bcd_adj[7:4] = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
    bcd_next     = 8'({bcd_adj, shift_copy[6]});
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = MUL;
      MUL:     if (last_mul)   state_next = CONV;
      CONV:    if (last_conv)  state_next = SHOW;
      SHOW:    if (last_dwell) state_next = MUL;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rstn) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      n          <= '0;
      acc        <= '0;
      bcd        <= '0;
      shift_copy <= '0;
      iter       <= '0;
      dwell      <= '0;
      n_tens     <= '0;
      n_ones     <= '0;
      sq_tens    <= '0;
      sq_ones    <= '0;
    end else begin
      case (state)
        IDLE: begin
          acc  <= '0;
          iter <= '0;
        end
        MUL: begin
          acc <= acc_next;
          if (last_mul) begin
            iter       <= '0;
            shift_copy <= acc_next;
            bcd        <= '0;
          end else begin
            iter <= iter + 3'd1;
          end
        end
        CONV: begin
          bcd        <= bcd_next;
          shift_copy <= shift_copy << 1;
          if (last_conv) begin
            // The final shift result is loaded straight into the digit registers.
            iter    <= '0;
            dwell   <= '0;
            n_tens  <= 4'd0;
            n_ones  <= n;
            sq_tens <= bcd_next[7:4];
            sq_ones <= bcd_next[3:0];
          end else begin
            iter <= iter + 3'd1;
          end
        end
        SHOW: begin
          if (last_dwell) begin
            n    <= (n == 4'd9) ? 4'd0 : n + 4'd1;
            acc  <= '0;
            iter <= '0;
          end else begin
            dwell <= dwell + 24'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign LED_RED   = (state == MUL) || (state == CONV);
  assign LED_GREEN = (state == SHOW);

  assign SS1_1 = seg7(n_tens);
  assign SS1_0 = seg7(n_ones);
  assign SS2_1 = seg7(sq_tens);
  assign SS2_0 = seg7(sq_ones);

endmodule

// File: tb/tb_square_display.sv
// Directed bench for square_display: expected displays are queued per n and
// compared when SHOW is entered; LED and hold behaviour checked every cycle.
module tb_square_display;

  localparam int TICK = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       LED_RED, LED_GREEN;
  logic [6:0] SS1_1, SS1_0, SS2_1, SS2_0;

  typedef struct {
    logic [6:0] s11, s10, s21, s20;
  } exp_t;

  exp_t       sb[$];
  logic [6:0] shown[4];
  int         n_checks = 0;
  int         n_errors = 0;

  square_display #(.TICK_DIV(TICK)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .LED_RED  (LED_RED),
    .LED_GREEN(LED_GREEN),
    .SS1_1    (SS1_1),
    .SS1_0    (SS1_0),
    .SS2_1    (SS2_1),
    .SS2_0    (SS2_0)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check_leds(input string tag, input logic red, input logic green);
    n_checks++;
    assert ({LED_RED, LED_GREEN} === {red, green}) else begin
      n_errors++;
      $error("FAIL %s: observed red/green %b%b expected %b%b", tag, LED_RED, LED_GREEN, red, green);
    end
  endtask

  task automatic check_held(input string tag);
    check({tag, "_ss1_1"}, SS1_1, shown[0]);
    check({tag, "_ss1_0"}, SS1_0, shown[1]);
    check({tag, "_ss2_1"}, SS2_1, shown[2]);
    check({tag, "_ss2_0"}, SS2_0, shown[3]);
  endtask

  task automatic push_expected(input int nv);
    int   sq;
    exp_t e;
    sq    = nv * nv;
    e.s11 = seg_of(0);
    e.s10 = seg_of(nv);
    e.s21 = seg_of(sq / 10);
    e.s20 = seg_of(sq % 10);
    sb.push_back(e);
  endtask

  task automatic reset_shown();
    for (int i = 0; i < 4; i++) shown[i] = 7'h3F;
  endtask

  // Entered just after the edge into MUL; returns just after the next MUL entry.
  task automatic do_result(input string tag);
    exp_t e;
    for (int k = 1; k <= 10; k++) begin
      step();
      check_leds({tag, "_busy"}, 1'b1, 1'b0);
      check_held({tag, "_busy_hold"});
    end
    step();
    check_leds({tag, "_show_entry"}, 1'b0, 1'b1);
    check({tag, "_sb_nonempty"}, 7'(sb.size() != 0), 7'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_ss1_1"}, SS1_1, e.s11);
      check({tag, "_ss1_0"}, SS1_0, e.s10);
      check({tag, "_ss2_1"}, SS2_1, e.s21);
      check({tag, "_ss2_0"}, SS2_0, e.s20);
      shown = '{e.s11, e.s10, e.s21, e.s20};
    end
    for (int j = 1; j < TICK; j++) begin
      step();
      check_leds({tag, "_dwell"}, 1'b0, 1'b1);
      check_held({tag, "_dwell_hold"});
    end
    step();
    check_leds({tag, "_next_mul"}, 1'b1, 1'b0);
    check_held({tag, "_next_hold"});
  endtask

  initial begin
    reset_shown();
    rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check_leds("reset_leds", 1'b0, 1'b0);
      check_held("reset");
    end

    rstn = 1'b0;
    step();
    check_leds("edge1_mul", 1'b1, 1'b0);
    check_held("edge1");

    for (int nv = 0; nv <= 9; nv++) begin
      push_expected(nv);
      do_result($sformatf("n%0d", nv));
    end
    for (int nv = 0; nv <= 4; nv++) begin
      push_expected(nv);
      do_result($sformatf("wrap_n%0d", nv));
    end

    // Now just inside MUL for n=5: move into CONV, then reset mid-conversion.
    for (int k = 0; k < 6; k++) begin
      step();
      check_leds("n5_busy", 1'b1, 1'b0);
      check_held("n5_busy_hold");
    end
    rstn = 1'b1;
    step();
    reset_shown();
    check_leds("midconv_reset_leds", 1'b0, 1'b0);
    check_held("midconv_reset");
    rstn = 1'b0;
    step();
    check_leds("restart_edge1", 1'b1, 1'b0);
    check_held("restart_edge1");
    push_expected(0);
    do_result("restart_n0");
    push_expected(1);
    do_result("restart_n1");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
